qarctan_stream: RTL and testbench
=================================

// Module: qarctan_stream
// PURPOSE
//  Parametrised quadrature-arctangent stage for the FM demod chain: angle = atan2(y,x) in
//  fixed point, via r = (x-|y|)/(x+|y|) (x>=0) or (x+|y|)/(|y|-x) (x<0), angle = Q1 - Q1*r or Q3 - Q1*r.
//  Sits between demod conjugate-multiply and de-emphasis. Full valid/ready both sides, tagged
//  channels, zero-input bypass, back-to-back issue.
// PARAMETERS
//  DATA_WIDTH  32    signed width of x, y and out_angle
//  FRAC_BITS   10    quantisation shift (QUANTIZE = <<<F, DEQUANTIZE = round-toward-zero >>>F)
//  TAG_WIDTH   1     channel tag carried alongside each sample (L/R, pilot, ...)
//  QUAD_ONE    804   pi/4 * 2^FRAC_BITS (0x324 at F=10)
//  QUAD_THREE  2412  3pi/4 * 2^FRAC_BITS (0x96c at F=10)
// PORTS
//  clk        in   1           clock
//  reset_n    in   1           one clock; reset is asynchronous and active-low
//  in_valid   in   1           x/y/tag valid
//  in_ready   out  1           stage can accept (transfer on in_valid & in_ready)
//  in_x       in   DATA_WIDTH  signed real part
//  in_y       in   DATA_WIDTH  signed imaginary part
//  in_tag     in   TAG_WIDTH   channel tag
//  out_valid  out  1           angle valid; held until out_ready
//  out_ready  in   1           downstream accept
//  out_angle  out  DATA_WIDTH  signed angle, scale pi = 4*QUAD_ONE
//  out_tag    out  TAG_WIDTH   tag of that sample
//  busy       out  1           high in any state but IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1 after release, out_valid=0, out_angle=0, out_tag=0, busy=0; divider reset (~reset_n).
//  Reset mid-operation: sample discarded, no out_valid, divider flushed; no partial result ever emitted.
//  FSM: IDLE -> PREP -> DIV_LAUNCH -> DIV_WAIT -> SCALE -> OUT -> IDLE.
//   IDLE: in_ready=1; on transfer capture x,y,tag into regs (inputs never re-read later).
//   PREP: |y| = (y<0 ? -y : y) + 1, saturate at 2^(DW-1)-1 for y=min; sums at DW+2 bits (no wrap).
//         Select num/den by sign of x. If x==0 && y==0 -> angle=2*QUAD_ONE, go straight to OUT.
//   DIV_LAUNCH: valid_in=1 exactly one cycle; dividend = num<<<F sign-extended to DW+F+2; divisor = den (always >=1).
//   DIV_WAIT: wait for div valid_out; latch quotient. Divider overflow -> clamp r to +/-2^F.
//   SCALE: p = QUAD_ONE*r (signed, full width); d = p<0 ? (p+2^F-1)>>>F : p>>>F;
//          a = (x>=0 ? QUAD_ONE : QUAD_THREE) - d; out_angle = y<0 ? -a : a, registered.
//   OUT: out_valid=1; out_angle/out_tag stable until out_valid & out_ready.
//  Back-to-back: in OUT, in_ready = out_ready; simultaneous out/in handshake captures new sample, goes to PREP.
//  Latency accept->out_valid: 5 + divider latency; zero bypass: 2 cycles. One sample in flight max.
//  in_valid/in_x/in_y ignored while in_ready=0; out_ready ignored while out_valid=0.
// STRUCTURE
//  qarctan_pkg: state_t enum, qarctan_quantize()/qarctan_dequantize() functions, default QUAD constants.
//  One sub-module: existing div (DIVIDEND_WIDTH=DW+F+2, DIVISOR_WIDTH=DW+2), reset driven by ~reset_n.
//  Top: capture regs, FSM, PREP combinational select, SCALE multiply + rounding, output regs.
// TESTING (DW=32, F=10, defaults)
//  x=1024,y=0 -> r=1022, out_angle=2, tag echoed.
//  x=0,y=1024 -> out_angle=1608; x=0,y=-1024 -> out_angle=-1608.
//  x=-1024,y=0 -> r=-1022, out_angle=3214.
//  x=0,y=0 -> bypass, out_angle=1608 exactly 2 cycles after accept, divider valid_in never pulsed.
//  out_ready=0 for 10 cycles in OUT -> out_angle/out_tag stable, in_ready=0; then out_ready=1 with
//   in_valid=1 same cycle -> both transfers occur, next sample processed, no bubble in IDLE.
//  reset_n low during DIV_WAIT -> outputs zero immediately, no out_valid after release; next sample correct.

Source files
------------

// File: rtl/qarctan_pkg.sv
// Shared types, default angle constants and fixed-point helpers for the
// quadrature-arctangent stage.
package qarctan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_DIV_LAUNCH,
    ST_DIV_WAIT,
    ST_SCALE,
    ST_OUT
  } state_t;

  localparam int QUAD_ONE_DEF   = 804;   // pi/4  * 2^10
  localparam int QUAD_THREE_DEF = 2412;  // 3pi/4 * 2^10

  function automatic logic signed [63:0] qarctan_quantize(input logic signed [63:0] v,
                                                         input int frac);
    return v <<< frac;
  endfunction

  // Arithmetic shift rounds toward -inf, so bias negatives to get round-toward-zero.
  function automatic logic signed [63:0] qarctan_dequantize(input logic signed [63:0] v,
                                                           input int frac);
    if (v < 0) return (v + (64'sd1 <<< frac) - 64'sd1) >>> frac;
    return v >>> frac;
  endfunction

endpackage

// File: rtl/qarctan_stream_if.sv
// Sample-in / angle-out stream bundle. Both sides use valid/ready: a transfer
// happens on a rising edge where valid & ready; valid, once raised, holds its payload until then.
interface qarctan_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 1
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_x;
  logic signed [DATA_WIDTH-1:0] in_y;
  logic [TAG_WIDTH-1:0]         in_tag;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_angle;
  logic [TAG_WIDTH-1:0]         out_tag;

  modport slave (
    input  in_valid, in_x, in_y, in_tag, out_ready,
    output in_ready, out_valid, out_angle, out_tag
  );

  modport master (
    output in_valid, in_x, in_y, in_tag, out_ready,
    input  in_ready, out_valid, out_angle, out_tag
  );
endinterface

// File: rtl/qarctan_stream_div.sv
// Sequential signed restoring divider, one quotient bit per cycle,
// truncating toward zero; overflow flags a zero divisor.
module qarctan_stream_div #(
  parameter int DIVIDEND_WIDTH = 44,
  parameter int DIVISOR_WIDTH  = 34
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             valid_in,
  input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
  input  logic signed [DIVISOR_WIDTH-1:0]  divisor,
  output logic                             valid_out,
  output logic signed [DIVIDEND_WIDTH-1:0] quotient,
  output logic                             overflow
);
  localparam int DDW = DIVIDEND_WIDTH;
  localparam int DVW = DIVISOR_WIDTH;
  localparam int CW  = $clog2(DDW + 1);

  logic           run_q, run_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DDW-1:0] quo_q, quo_d;
  logic [DVW-1:0] rem_q, rem_d;
  logic [DVW-1:0] dvs_q, dvs_d;
  logic           neg_q, neg_d;
  logic           valid_out_q, valid_out_d;
  logic [DDW-1:0] quotient_q, quotient_d;
  logic           overflow_q, overflow_d;
  logic [DVW:0]   trial;

  always_comb begin
    run_d       = run_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    neg_d       = neg_q;
    valid_out_d = 1'b0;
    quotient_d  = quotient_q;
    overflow_d  = overflow_q;
    trial       = {rem_q, quo_q[DDW-1]};
    if (!run_q) begin
      if (valid_in) begin
        run_d = 1'b1;
        cnt_d = CW'(DDW);
        quo_d = dividend[DDW-1] ? -dividend : dividend;
        rem_d = '0;
        dvs_d = divisor[DVW-1] ? -divisor : divisor;
        neg_d = dividend[DDW-1] ^ divisor[DVW-1];
      end
    end else begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = DVW'(trial - {1'b0, dvs_q});
        quo_d = {quo_q[DDW-2:0], 1'b1};
      end else begin
        rem_d = trial[DVW-1:0];
        quo_d = {quo_q[DDW-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        run_d       = 1'b0;
        valid_out_d = 1'b1;
        quotient_d  = neg_q ? -quo_d : quo_d;
        overflow_d  = (dvs_q == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q       <= 1'b0;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      neg_q       <= 1'b0;
      valid_out_q <= 1'b0;
      quotient_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      run_q       <= run_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      neg_q       <= neg_d;
      valid_out_q <= valid_out_d;
      quotient_q  <= quotient_d;
      overflow_q  <= overflow_d;
    end
  end

  assign valid_out = valid_out_q;
  assign quotient  = quotient_q;
  assign overflow  = overflow_q;
endmodule

// File: rtl/qarctan_stream.sv
// atan2(y,x) stage: ratio r = (x-|y|)/(x+|y|) (or mirrored for x<0) through a
// sequential divider, then angle = Q1 - Q1*r or Q3 - Q1*r, sign taken from y.
module qarctan_stream
  import qarctan_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  parameter int TAG_WIDTH  = 1,
  parameter int QUAD_ONE   = QUAD_ONE_DEF,
  parameter int QUAD_THREE = QUAD_THREE_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  qarctan_stream_if.slave bus,
  output logic            busy,
  output state_t          dbg_state
);
  localparam int DW  = DATA_WIDTH;
  localparam int F   = FRAC_BITS;
  localparam int SW  = DW + 2;
  localparam int DDW = DW + F + 2;
  localparam int RW  = F + 2;
  localparam logic [DW:0]          AY_MAX = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [63:0]   R_MAX  = 64'sd1 <<< F;

  state_t                 state_q, state_d;
  logic signed [DW-1:0]   x_q, x_d, y_q, y_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic signed [SW-1:0]   num_q, num_d, den_q, den_d;
  logic signed [RW-1:0]   r_q, r_d;
  logic signed [DW-1:0]   out_angle_q, out_angle_d;
  logic [TAG_WIDTH-1:0]   out_tag_q, out_tag_d;
  logic                   out_valid_q, out_valid_d;

  logic signed [DW:0]     y_ext;
  logic [DW:0]            y_mag, ay_w;
  logic signed [SW-1:0]   ay_s, x_s;
  logic signed [63:0]     q64, p64, d64, a64;

  logic                   div_valid_in, div_valid_out, div_overflow;
  logic signed [DDW-1:0]  div_dividend, div_quotient;

  assign div_valid_in = (state_q == ST_DIV_LAUNCH);
  assign div_dividend = DDW'(qarctan_quantize(64'(num_q), F));

  qarctan_stream_div #(
    .DIVIDEND_WIDTH(DDW),
    .DIVISOR_WIDTH (SW)
  ) u_div (
    .clk      (clk),
    .reset    (~reset_n),
    .valid_in (div_valid_in),
    .dividend (div_dividend),
    .divisor  (den_q),
    .valid_out(div_valid_out),
    .quotient (div_quotient),
    .overflow (div_overflow)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    tag_d       = tag_q;
    num_d       = num_q;
    den_d       = den_q;
    r_d         = r_q;
    out_angle_d = out_angle_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
    // |y|+1 keeps the denominator >= 1; y = min would overflow, so saturate.
    y_ext = {y_q[DW-1], y_q};
    y_mag = y_q[DW-1] ? -y_ext : y_ext;
    ay_w  = y_mag + 1'b1;
    if (ay_w > AY_MAX) ay_w = AY_MAX;
    ay_s = $signed({1'b0, ay_w});
    x_s  = $signed({{2{x_q[DW-1]}}, x_q});
    q64  = 64'(div_quotient);
    p64  = 64'(QUAD_ONE) * 64'(r_q);
    d64  = qarctan_dequantize(p64, F);
    a64  = (x_q[DW-1] ? 64'(QUAD_THREE) : 64'(QUAD_ONE)) - d64;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.in_x;
          y_d     = bus.in_y;
          tag_d   = bus.in_tag;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        if (x_q == '0 && y_q == '0) begin
          out_angle_d = DW'(2 * QUAD_ONE);
          out_tag_d   = tag_q;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          if (!x_q[DW-1]) begin
            num_d = x_s - ay_s;
            den_d = x_s + ay_s;
          end else begin
            num_d = x_s + ay_s;
            den_d = ay_s - x_s;
          end
          state_d = ST_DIV_LAUNCH;
        end
      end
      ST_DIV_LAUNCH: state_d = ST_DIV_WAIT;
      ST_DIV_WAIT: begin
        if (div_valid_out) begin
          if (div_overflow || q64 > R_MAX) r_d = RW'(R_MAX);
          else if (q64 < -R_MAX)           r_d = RW'(-R_MAX);
          else                             r_d = RW'(q64);
          state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        out_angle_d = DW'(y_q[DW-1] ? -a64 : a64);
        out_tag_d   = tag_q;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        // A new sample may be taken on the same edge the result leaves.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
          if (bus.in_valid) begin
            x_d     = bus.in_x;
            y_d     = bus.in_y;
            tag_d   = bus.in_tag;
            state_d = ST_PREP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      tag_q       <= '0;
      num_q       <= '0;
      den_q       <= '0;
      r_q         <= '0;
      out_angle_q <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      tag_q       <= tag_d;
      num_q       <= num_d;
      den_q       <= den_d;
      r_q         <= r_d;
      out_angle_q <= out_angle_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE) || (state_q == ST_OUT && bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_angle = out_angle_q;
  assign bus.out_tag   = out_tag_q;
  assign busy          = (state_q != ST_IDLE);
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_qarctan_stream.sv
// Directed bench for qarctan_stream: hand-computed angles, zero bypass,
// output stall with back-to-back issue, and reset during a division.
module tb_qarctan_stream;
  import qarctan_pkg::*;

  localparam int DW = 32;
  localparam int F  = 10;
  localparam int TW = 1;
  localparam int W  = DW + TW;

  logic   clk     = 1'b0;
  logic   reset_n = 1'b1;
  logic   busy;
  state_t dbg_state;

  qarctan_stream_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  qarctan_stream #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (F),
    .TAG_WIDTH (TW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int             n_checks    = 0;
  int             n_fail      = 0;
  int             n_out       = 0;
  int             div_pulses  = 0;
  int             div_expect  = 0;
  logic [W-1:0]   exp_q[$];

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (dut.div_valid_in) div_pulses++;
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("out_without_expect", 64'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check_eq($sformatf("angle%0d", n_out), bus.out_angle, $signed(e[DW-1:0]));
        check_eq($sformatf("tag%0d", n_out), bus.out_tag, e[W-1:DW]);
      end
      n_out++;
    end
  end

  // ---------------- driver tasks (call at posedge + #1) ----------------
  task automatic send(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y,
                      input logic [TW-1:0] tag, input logic signed [DW-1:0] exp_angle,
                      input string name);
    logic accepted = 1'b0;
    exp_q.push_back({tag, exp_angle});
    if (x != 0 || y != 0) div_expect++;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_tag   = tag;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_x     = $urandom();
    bus.in_y     = $urandom();
    bus.in_tag   = TW'($urandom_range(0, 1));
    check_eq({name, "_accept"}, accepted, 1);
  endtask

  task automatic wait_idle(input string name);
    logic done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (dbg_state == ST_IDLE);
    end
    check_eq({name, "_drain"}, done, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  logic signed [DW-1:0] vx [12] = '{32'sd1024, 32'sd0, 32'sd0, -32'sd1024, 32'sd1024,
                                    -32'sd1024, 32'sd0, 32'sd0, 32'sh8000_0000,
                                    32'sh7fff_ffff, -32'sd1000, 32'sd3000};
  logic signed [DW-1:0] vy [12] = '{32'sd0, 32'sd1024, -32'sd1024, 32'sd0, 32'sd1024,
                                    -32'sd1024, -32'sd1, 32'sh8000_0000, 32'sd0,
                                    32'sd0, 32'sd500, -32'sd1000};
  logic signed [DW-1:0] va [12] = '{32'sd2, 32'sd1608, -32'sd1608, 32'sd3214, 32'sd804,
                                    -32'sd2412, -32'sd1608, -32'sd1608, 32'sd3215,
                                    32'sd1, 32'sd2678, -32'sd403};

  initial begin
    logic got;
    int   seen;
    int   p0;

    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_angle", bus.out_angle, 0);
    check_eq("rst_out_tag", bus.out_tag, 0);
    check_eq("rst_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_state", dbg_state, ST_IDLE);
    @(posedge clk);
    #1;

    // Main function, issued back to back.
    for (int i = 0; i < 12; i++)
      send(vx[i], vy[i], TW'(i % 2), va[i], $sformatf("vec%0d", i));
    wait_idle("vectors");

    // Zero input: bypass straight to OUT, divider untouched.
    p0 = div_pulses;
    exp_q.push_back({1'b1, 32'sd1608});
    bus.in_valid = 1'b1;
    bus.in_x     = '0;
    bus.in_y     = '0;
    bus.in_tag   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("bypass_c1_valid", bus.out_valid, 0);
    check_eq("bypass_c1_state", dbg_state, ST_PREP);
    @(posedge clk);
    #1;
    check_eq("bypass_c2_valid", bus.out_valid, 1);
    check_eq("bypass_c2_angle", bus.out_angle, 1608);
    wait_idle("bypass");
    check_eq("bypass_no_div", div_pulses, p0);

    // Stall in OUT, then release together with a new sample.
    bus.out_ready = 1'b0;
    send(32'sd1024, 32'sd0, 1'b1, 32'sd2, "stall");
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = bus.out_valid;
    end
    check_eq("stall_out_valid", got, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq($sformatf("stall_angle_c%0d", i), bus.out_angle, 2);
      check_eq($sformatf("stall_tag_c%0d", i), bus.out_tag, 1);
      check_eq($sformatf("stall_in_ready_c%0d", i), bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    exp_q.push_back({1'b0, 32'sd1608});
    div_expect++;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_x      = 32'sd0;
    bus.in_y      = 32'sd1024;
    bus.in_tag    = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_x     = $urandom();
    check_eq("b2b_state", dbg_state, ST_PREP);
    check_eq("b2b_out_valid", bus.out_valid, 0);
    wait_idle("b2b");

    // Reset while the divider is busy: sample dropped, nothing emitted.
    div_expect++;
    bus.in_valid = 1'b1;
    bus.in_x     = 32'sd1024;
    bus.in_y     = 32'sd0;
    bus.in_tag   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = (dbg_state == ST_DIV_WAIT);
    end
    check_eq("mid_reach_wait", got, 1);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_angle", bus.out_angle, 0);
    check_eq("mid_rst_valid", bus.out_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check_eq("mid_no_out_valid", seen, 0);
    @(posedge clk);
    #1;
    send(-32'sd1024, 32'sd0, 1'b1, 32'sd3214, "after_rst");
    wait_idle("after_rst");

    check_eq("div_launch_count", div_pulses, div_expect);
    check_eq("exp_q_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
